wam_mole: RTL and testbench
===========================

Name: wam_mole

Overview:
- Mole generator stage, directly upstream of the hit-detection stage.
- Drives the `holes` vector that the hit stage compares against player taps.
- Consumes the registered `hit` vector the hit stage returns, to knock moles down.
- Spawns moles pseudo-randomly at a fixed interval and retires unhit moles after a difficulty-scaled lifetime, flagging each retirement as a miss for scoring.

Parameters:
- SPAWN_TICKS, 24: clk_19 cycles between spawn attempts; legal range 1..255.
- LIFE_TICKS, 40: base mole lifetime in clk_19 cycles; legal range 1..255.
- MAX_MOLES, 3: maximum simultaneously raised moles; legal range 1..8.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk_19  in  1  game clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- run  in  1  game active; low freezes game state.
- level  in  2  difficulty; lifetime = LIFE_TICKS >> level.
- hit  in  8  effective hits from the hit stage, active high.
- holes  out  8  raised moles, active high, registered.
- spawn  out  1  one-cycle pulse, coincident with the new hole bit rising.
- miss  out  8  one-cycle pulse per hole whose mole expired unhit.

Behaviour:
- Reset, checked at posedge while rst_n=0:
  - holes=0, miss=0, spawn=0.
  - Spawn counter=0, all life counters=0, LFSR=LFSR_SEED.
  - Reset mid-game clears everything at that edge; no miss is generated for moles that were up.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle out of reset, independent of run.
- Spawn counter, 8 bits:
  - Increments while run=1.
  - At count==SPAWN_TICKS-1 it wraps to 0 and a spawn attempt occurs at that edge.
  - Example: with SPAWN_TICKS=4 and run high from cycle 0, holes first rises at edge 4.
- Spawn attempt:
  - If popcount(holes) >= MAX_MOLES: no spawn; the counter still wraps.
  - Otherwise idx = lfsr[2:0]. Probe idx, idx+1, ... mod 8 over the current registered holes and take the first 0 bit.
  - Set that bit, load its life counter with L, and pulse spawn.
  - A hole clearing in the same cycle still reads as occupied, so it is skipped.
- Lifetime L = LIFE_TICKS >> level, clamped to a minimum of 1. It is sampled at spawn; a later level change does not affect live moles.
- Per-hole life counter, 8 bits:
  - Decrements each cycle while holes[i]=1 and run=1.
  - When life==1, not hit, and run=1: at the next edge holes[i]=0 and miss[i]=1 for exactly one cycle.
  - Resulting visible lifetime is exactly L cycles.
- Hit handling:
  - hit[i]=1 with holes[i]=1: holes[i]=0 at the next edge, life counter zeroed, no miss.
  - hit[i] on an empty hole is ignored. Late hits arriving after expiry are harmless.
  - Hit and expiry in the same cycle: the hit wins, no miss.
- run=0:
  - Spawn counter and life counters freeze; holes hold their value; no spawns.
  - Hits are still honoured (a hit clears its hole).
  - miss and spawn stay 0.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package wam_pkg holds:
  - NUM_HOLES=8.
  - LFSR_W=16 and the tap mask 16'hB400.
  - Default seed.
  - Life/spawn counter width (8).
- Sub-module wam_lfsr (clk_19, rst_n, seed, out[15:0]), reusable by other random stages.
- Free-hole probe is a combinational function inside wam_mole.

Test Plan:
- Reset and spawn timing:
  - Stimulus: SPAWN_TICKS=4; hold rst_n=0 for 3 cycles with run=1 and hit=8'hFF; then release.
  - Response: holes=0, miss=0 and spawn=0 during reset; first spawn pulse and single hole bit at the 4th edge after release; one spawn every 4 cycles thereafter.
- Expiry:
  - Stimulus: LIFE_TICKS=8, level=0, hit=0.
  - Response: each mole is high exactly 8 cycles; miss[i] pulses one cycle, aligned with holes[i] falling; popcount never exceeds MAX_MOLES.
- Level scaling:
  - Stimulus: LIFE_TICKS=8 with level=2; then LIFE_TICKS=4 with level=3.
  - Response: lifetime is 2 cycles, then 1 cycle (clamped).
  - Stimulus: change level while a mole is up.
  - Response: that mole keeps its original lifetime.
- Hits:
  - Stimulus: hit[i] pulse 3 cycles after holes[i] rises.
  - Response: holes[i]=0 at the next edge, no miss.
  - Stimulus: hit=8'h01 while holes[0]=0.
  - Response: holes and miss unchanged.
  - Stimulus: hit[i] in the cycle where life==1.
  - Response: holes[i] clears, miss stays 0.
- Saturation and run gating:
  - Stimulus: MAX_MOLES=3, LIFE_TICKS=255, SPAWN_TICKS=4.
  - Response: popcount(holes) stops at 3 and spawn stops; after hitting one hole, the next attempt spawns into a free hole.
  - Stimulus: run=0 for 10 cycles.
  - Response: holes unchanged, no spawn or miss; remaining lifetimes resume unchanged when run returns.
- Reset mid-game:
  - Stimulus: rst_n=0 for one cycle with 3 moles up.
  - Response: holes=0 and miss=0 at that edge; LFSR returns to seed and the spawn sequence repeats identically to the first run.

Source files
------------

// File: rtl/wam_pkg.sv
// wam_pkg: shared constants for the whack-a-mole stages
package wam_pkg;
    localparam int              NUM_HOLES     = 8;
    localparam int              HOLE_W        = 3;
    localparam int              LFSR_W        = 16;
    localparam logic [15:0]     LFSR_TAPS     = 16'hB400;
    localparam logic [15:0]     LFSR_SEED_DEF = 16'hACE1;
    localparam int              CNT_W         = 8;
endpackage

// File: rtl/wam_lfsr.sv
// wam_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running out of reset
module wam_lfsr import wam_pkg::*; (
    input  logic              clk_19,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] out
);
    always_ff @(posedge clk_19) begin
        if (!rst_n) out <= seed;
        else        out <= {out[LFSR_W-2:0], ^(out & LFSR_TAPS)};
    end
endmodule

// File: rtl/wam_mole.sv
// wam_mole: spawns moles at a fixed interval into pseudo-random free holes,
// retires them on hit or after a level-scaled lifetime (flagging a miss)
module wam_mole import wam_pkg::*; #(
    parameter int                SPAWN_TICKS = 24,
    parameter int                LIFE_TICKS  = 40,
    parameter int                MAX_MOLES   = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic                 clk_19,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [1:0]           level,
    input  logic [NUM_HOLES-1:0] hit,
    output logic [NUM_HOLES-1:0] holes,
    output logic                 spawn,
    output logic [NUM_HOLES-1:0] miss
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [LFSR_W-1:0]    lfsr;
    logic                 unused_lfsr;
    logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d;
    logic [CNT_W-1:0]     life_q [NUM_HOLES];
    logic [CNT_W-1:0]     life_d [NUM_HOLES];
    logic [NUM_HOLES-1:0] holes_q, holes_d, miss_q, miss_d;
    logic                 spawn_q, spawn_d;
    logic                 attempt;
    logic [CNT_W-1:0]     life_raw, life_l;
    logic [HOLE_W:0]      probe_r;

    wam_lfsr u_lfsr (.clk_19(clk_19), .rst_n(rst_n), .seed(LFSR_SEED), .out(lfsr));

    assign unused_lfsr = ^lfsr[LFSR_W-1:HOLE_W];

    // First free hole at or after idx (wrapping); MSB flags success
    function automatic logic [HOLE_W:0] probe(input logic [NUM_HOLES-1:0] h,
                                              input logic [HOLE_W-1:0] idx);
        logic [HOLE_W-1:0] j;
        probe = '0;
        for (int k = NUM_HOLES - 1; k >= 0; k--) begin
            j = idx + HOLE_W'(k);
            if (!h[j]) probe = {1'b1, j};
        end
    endfunction

    assign attempt  = run && (spawn_cnt_q == CNT_W'(SPAWN_TICKS - 1));
    assign life_raw = CNT_W'(LIFE_TICKS) >> level;
    assign life_l   = (life_raw == '0) ? ONE : life_raw;
    assign probe_r  = probe(holes_q, lfsr[HOLE_W-1:0]);

    always_comb begin
        spawn_cnt_d = run ? (attempt ? '0 : spawn_cnt_q + ONE) : spawn_cnt_q;
        holes_d     = holes_q;
        miss_d      = '0;
        spawn_d     = 1'b0;
        life_d      = life_q;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (holes_q[i] && hit[i]) begin
                holes_d[i] = 1'b0;
                life_d[i]  = '0;
            end else if (holes_q[i] && run) begin
                life_d[i]  = life_q[i] - ONE;
                holes_d[i] = (life_q[i] != ONE);
                miss_d[i]  = (life_q[i] == ONE);
            end
        end
        // Probe sees registered holes, so a hole clearing this cycle stays occupied
        if (attempt && ($countones(holes_q) < MAX_MOLES) && probe_r[HOLE_W]) begin
            holes_d[probe_r[HOLE_W-1:0]] = 1'b1;
            life_d[probe_r[HOLE_W-1:0]]  = life_l;
            spawn_d                      = 1'b1;
        end
    end

    always_ff @(posedge clk_19) begin
        if (!rst_n) begin
            spawn_cnt_q <= '0;
            life_q      <= '{default: '0};
            holes_q     <= '0;
            miss_q      <= '0;
            spawn_q     <= 1'b0;
        end else begin
            spawn_cnt_q <= spawn_cnt_d;
            life_q      <= life_d;
            holes_q     <= holes_d;
            miss_q      <= miss_d;
            spawn_q     <= spawn_d;
        end
    end

    assign holes = holes_q;
    assign miss  = miss_q;
    assign spawn = spawn_q;
endmodule

// File: tb/tb_wam_mole.sv
// tb_wam_mole: three wam_mole configurations checked against a per-hole
// remaining-lifetime model plus direct timing checks
module tb_wam_mole;
    import wam_pkg::*;

    localparam int LIF [3] = '{8, 4, 255};
    localparam int SPW  = 4;
    localparam int MAXM = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [1:0] level = 2'd0;
    logic [7:0] hit [3];
    logic [7:0] holes [3];
    logic [7:0] miss [3];
    logic       spawn [3];

    int          rem [3][8];
    int          cnt [3];
    logic [15:0] lf [3];
    logic [7:0]  mmiss [3];
    logic        msp [3];

    int         cyc = 0;
    int         rise_t [3][8];
    int         dur [3][8];
    logic [7:0] fell [3];
    logic [7:0] prev [3];
    logic [7:0] first_seq [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    wam_mole #(.SPAWN_TICKS(4), .LIFE_TICKS(8), .MAX_MOLES(3)) u0 (
        .clk_19(clk), .rst_n(rst_n), .run(run), .level(level), .hit(hit[0]),
        .holes(holes[0]), .spawn(spawn[0]), .miss(miss[0]));
    wam_mole #(.SPAWN_TICKS(4), .LIFE_TICKS(4), .MAX_MOLES(3)) u1 (
        .clk_19(clk), .rst_n(rst_n), .run(run), .level(level), .hit(hit[1]),
        .holes(holes[1]), .spawn(spawn[1]), .miss(miss[1]));
    wam_mole #(.SPAWN_TICKS(4), .LIFE_TICKS(255), .MAX_MOLES(3)) u2 (
        .clk_19(clk), .rst_n(rst_n), .run(run), .level(level), .hit(hit[2]),
        .holes(holes[2]), .spawn(spawn[2]), .miss(miss[2]));

    function automatic logic [7:0] mholes(input int k);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = rem[k][i] > 0;
        return r;
    endfunction

    function automatic int life_of(input int k);
        int l = LIF[k] >> level;
        return (l < 1) ? 1 : l;
    endfunction

    // One clock of the game rules, evaluated on the inputs the DUT is about to sample
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [7:0]  up  = mholes(k);
            logic [15:0] cur = lf[k];
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) rem[k][i] = 0;
                cnt[k] = 0; lf[k] = 16'hACE1; mmiss[k] = '0; msp[k] = 1'b0;
            end else begin
                lf[k] = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
                mmiss[k] = '0; msp[k] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (up[i] && hit[k][i]) rem[k][i] = 0;
                    else if (up[i] && run) begin
                        rem[k][i]--;
                        if (rem[k][i] == 0) mmiss[k][i] = 1'b1;
                    end
                end
                if (run && cnt[k] == SPW - 1) begin
                    cnt[k] = 0;
                    if ($countones(up) < MAXM) begin
                        for (int s = 0; s < 8; s++) begin
                            int j = (int'(cur[2:0]) + s) % 8;
                            if (!up[j]) begin
                                rem[k][j] = life_of(k); msp[k] = 1'b1;
                                break;
                            end
                        end
                    end
                end else if (run) cnt[k]++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (holes[k][i] === 1'b1 && prev[k][i] !== 1'b1) rise_t[k][i] = cyc;
                fell[k][i] = (prev[k][i] === 1'b1 && holes[k][i] === 1'b0);
                if (fell[k][i]) dur[k][i] = cyc - rise_t[k][i];
            end
            prev[k] = holes[k];
        end
    endtask

    task automatic wait_spawn(output int idx, output bit ok);
        ok = 0; idx = 0;
        for (int w = 0; w < 8 && !ok; w++) begin
            tick();
            if (spawn[0] === 1'b1) begin
                ok = 1;
                for (int b = 0; b < 8; b++) if (holes[0][b] && rise_t[0][b] == cyc) idx = b;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; run = 1; level = 0;
        for (int k = 0; k < 3; k++) hit[k] = 8'hFF;
        repeat (3) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({holes[k], miss[k], spawn[k]} !== 17'b0) begin
                    errors++;
                    $display("FAIL reset dut%0d holes=%h miss=%h spawn=%b required all 0", k, holes[k], miss[k], spawn[k]);
                end
            end
        end
        rst_n = 1;
        for (int k = 0; k < 3; k++) hit[k] = 8'h00;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (spawn[0] !== (n % 4 == 0) || (n < 4 && holes[0] !== 8'h00) || (n == 4 && $countones(holes[0]) != 1)) begin
                errors++;
                $display("FAIL spawn_timing edge=%0d spawn=%b holes=%h required spawn=%b", n, spawn[0], holes[0], n % 4 == 0);
            end
            checks++;
            if (holes[0] !== mholes(0)) begin
                errors++;
                $display("FAIL spawn_model edge=%0d holes=%h required %h", n, holes[0], mholes(0));
            end
            if (n % 4 == 0) first_seq[n/4 - 1] = holes[0];
        end
    endtask

    task automatic test_expiry();
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if ({holes[0], miss[0], spawn[0]} !== {mholes(0), mmiss[0], msp[0]}) begin
                errors++;
                $display("FAIL expiry_model cyc=%0d holes=%h miss=%h spawn=%b required %h %h %b", cyc, holes[0], miss[0], spawn[0], mholes(0), mmiss[0], msp[0]);
            end
            checks++;
            if ($countones(holes[0]) > MAXM || (miss[0] & ~fell[0]) != 8'h00) begin
                errors++;
                $display("FAIL expiry_pop cyc=%0d holes=%h miss=%h fell=%h", cyc, holes[0], miss[0], fell[0]);
            end
            for (int i = 0; i < 8; i++) if (fell[0][i]) begin
                checks++;
                if (dur[0][i] != 8 || miss[0][i] !== 1'b1) begin
                    errors++;
                    $display("FAIL expiry_life hole=%0d life=%0d miss=%b required life=8 miss=1", i, dur[0][i], miss[0][i]);
                end
            end
        end
    endtask

    task automatic test_level();
        int t0, idx;
        bit ok;
        level = 2; t0 = cyc;
        for (int n = 0; n < 48; n++) begin
            if (n == 24) begin level = 3; t0 = cyc; end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({holes[k], miss[k]} !== {mholes(k), mmiss[k]}) begin
                    errors++;
                    $display("FAIL level_model dut%0d cyc=%0d holes=%h miss=%h required %h %h", k, cyc, holes[k], miss[k], mholes(k), mmiss[k]);
                end
                for (int i = 0; i < 8; i++) if (fell[k][i] && rise_t[k][i] > t0) begin
                    checks++;
                    if (dur[k][i] != ((k == 0 && level == 2) ? 2 : 1)) begin
                        errors++;
                        $display("FAIL level_life dut%0d level=%0d hole=%0d life=%0d required %0d", k, level, i, dur[k][i], (k == 0 && level == 2) ? 2 : 1);
                    end
                end
            end
        end
        level = 0;
        wait_spawn(idx, ok);
        tick();
        level = 3;
        for (int w = 0; w < 12 && holes[0][idx]; w++) tick();
        checks++;
        if (!ok || holes[0][idx] !== 1'b0 || dur[0][idx] != 8 || miss[0][idx] !== 1'b1) begin
            errors++;
            $display("FAIL level_change spawned=%0d hole=%0d life=%0d miss=%b required life=8 miss=1", ok, idx, dur[0][idx], miss[0][idx]);
        end
        level = 0;
    endtask

    task automatic test_hits();
        int idx;
        bit ok;
        wait_spawn(idx, ok);
        tick(); tick();
        hit[0][idx] = 1'b1;
        tick();
        hit[0] = 8'h00;
        checks++;
        if (!ok || holes[0][idx] !== 1'b0 || miss[0][idx] !== 1'b0 || holes[0] !== mholes(0)) begin
            errors++;
            $display("FAIL hit_clear spawned=%0d hole=%0d holes=%h miss=%h required bit clear, holes=%h", ok, idx, holes[0], miss[0], mholes(0));
        end
        tick();
        checks++;
        if (miss[0] !== mmiss[0] || miss[0][idx] !== 1'b0) begin
            errors++;
            $display("FAIL hit_nomiss miss=%h required %h", miss[0], mmiss[0]);
        end
        for (int w = 0; w < 16 && holes[0][0]; w++) tick();
        hit[0] = 8'h01;
        tick();
        hit[0] = 8'h00;
        checks++;
        if ({holes[0], miss[0]} !== {mholes(0), mmiss[0]} || miss[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_empty holes=%h miss=%h required %h %h", holes[0], miss[0], mholes(0), mmiss[0]);
        end
        wait_spawn(idx, ok);
        repeat (7) tick();
        hit[0][idx] = 1'b1;
        tick();
        hit[0] = 8'h00;
        checks++;
        if (!ok || holes[0][idx] !== 1'b0 || miss[0][idx] !== 1'b0 || {holes[0], miss[0]} !== {mholes(0), mmiss[0]}) begin
            errors++;
            $display("FAIL hit_last hole=%0d holes=%h miss=%h required %h %h", idx, holes[0], miss[0], mholes(0), mmiss[0]);
        end
    endtask

    task automatic test_saturation();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int n = 1; n <= 24; n++) begin
            int exp_pop = (n <= 20) ? ((n / 4 > 3) ? 3 : n / 4) : ((n == 24) ? 3 : 2);
            logic exp_sp = (n % 4 == 0) && (n <= 12 || n == 24);
            logic [7:0] h = holes[2];
            if (n == 21) hit[2] = h & (~h + 8'd1);
            tick();
            hit[2] = 8'h00;
            checks++;
            if ($countones(holes[2]) != exp_pop || spawn[2] !== exp_sp || holes[2] !== mholes(2)) begin
                errors++;
                $display("FAIL saturation edge=%0d holes=%h spawn=%b required pop=%0d spawn=%b holes=%h", n, holes[2], spawn[2], exp_pop, exp_sp, mholes(2));
            end
        end
    endtask

    task automatic test_run_gating();
        logic [7:0] snap [3];
        int tf = cyc;
        for (int k = 0; k < 3; k++) snap[k] = holes[k];
        run = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (holes[k] !== snap[k] || spawn[k] !== 1'b0 || miss[k] !== 8'h00) begin
                    errors++;
                    $display("FAIL frozen dut%0d holes=%h spawn=%b miss=%h required holes=%h spawn=0 miss=00", k, holes[k], spawn[k], miss[k], snap[k]);
                end
            end
        end
        run = 1;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if ({holes[0], miss[0], holes[2]} !== {mholes(0), mmiss[0], mholes(2)}) begin
                errors++;
                $display("FAIL resume_model holes0=%h miss0=%h holes2=%h required %h %h %h", holes[0], miss[0], holes[2], mholes(0), mmiss[0], mholes(2));
            end
            for (int i = 0; i < 8; i++) if (fell[0][i] && snap[0][i] && rise_t[0][i] <= tf) begin
                checks++;
                if (dur[0][i] != 18) begin
                    errors++;
                    $display("FAIL resume_life hole=%0d life=%0d required 18", i, dur[0][i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if ($countones(holes[2]) != 3) begin
            errors++;
            $display("FAIL pre_reset_pop holes=%h required 3 moles", holes[2]);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({holes[k], miss[k], spawn[k]} !== 17'b0) begin
                errors++;
                $display("FAIL mid_reset dut%0d holes=%h miss=%h spawn=%b required all 0", k, holes[k], miss[k], spawn[k]);
            end
        end
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n % 4 == 0) begin
                checks++;
                if (holes[0] !== first_seq[n/4 - 1] || holes[0] !== mholes(0)) begin
                    errors++;
                    $display("FAIL replay edge=%0d holes=%h required %h", n, holes[0], first_seq[n/4 - 1]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            hit[k] = 8'h00; prev[k] = 8'h00; fell[k] = 8'h00;
            for (int i = 0; i < 8; i++) begin rise_t[k][i] = 0; dur[k][i] = 0; rem[k][i] = 0; end
        end
        test_reset();
        test_expiry();
        test_level();
        test_hits();
        test_saturation();
        test_run_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
